// File: rtl/temporizador_pisca_leds_pkg.sv
// Shared definitions for the hit-blink timer: FSM state encodings, default timing constants
// and the counter width helper.
// Latency: n/a (types and constants only). Backpressure: n/a.
package pisca_pkg;

    typedef enum logic [1:0] {
        OCIOSO    = 2'b00,
        ACESO     = 2'b01,
        APAGADO   = 2'b10,
        CONCLUIDO = 2'b11
    } estado_t;

    localparam int T_ON_PADRAO       = 25_000_000;
    localparam int T_OFF_PADRAO      = 25_000_000;
    localparam int N_PISCADAS_PADRAO = 3;

    // A counter modulo m needs $clog2(m) bits. At least one bit is kept so a modulus of 1
    // (a single blink) still gives a legal vector.
    function automatic int larguraContador(input int m);
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/temporizador_pisca_leds_if.sv
// Bus between the game control unit (master) and the hit-blink timer (slave).
// Latency: n/a (wires only). Backpressure: none; the enables are plain per-cycle strobes.
// Ports: zeraPisca/contaLedsOn/contaLedsOff/contaPiscadas from the master;
//        fimLedsOn/fimLedsOff/fimPiscaLeds/leds_acesos/erro/db_estado from the slave.
interface temporizador_pisca_leds_if;

    logic       zeraPisca;
    logic       contaLedsOn;
    logic       contaLedsOff;
    logic       contaPiscadas;
    logic       fimLedsOn;
    logic       fimLedsOff;
    logic       fimPiscaLeds;
    logic       leds_acesos;
    logic       erro;
    logic [1:0] db_estado;

    modport master (
        output zeraPisca, contaLedsOn, contaLedsOff, contaPiscadas,
        input  fimLedsOn, fimLedsOff, fimPiscaLeds, leds_acesos, erro, db_estado
    );

    modport slave (
        input  zeraPisca, contaLedsOn, contaLedsOff, contaPiscadas,
        output fimLedsOn, fimLedsOff, fimPiscaLeds, leds_acesos, erro, db_estado
    );

endinterface

// File: rtl/temporizador_pisca_leds_contador.sv
// Modulo-M counter: advances on conta, wraps to 0 after M-1, fim flags the terminal count.
// Latency: Q updates on the edge after conta; fim is combinational from Q (zero latency).
// Backpressure: none; zera is a synchronous clear that wins over conta.
// Ports: clock, reset_n (async, active-low), zera, conta, Q (count), fim (Q == M-1).
module contador_m
    import pisca_pkg::*;
#(
    parameter int M = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          zera,
    input  logic                          conta,
    output logic [larguraContador(M)-1:0] Q,
    output logic                          fim
);

    localparam int W = larguraContador(M);

    assign fim = (Q == W'(M - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            Q <= '0;
        end else if (zera) begin
            Q <= '0;
        end else if (conta) begin
            Q <= fim ? '0 : Q + W'(1);
        end
    end

endmodule

// File: rtl/temporizador_pisca_leds.sv
// Hit-blink timer: times LED on/off phases and counts blinks for the game control unit.
// Latency: fim* flags are zero-latency decodes of registers; FSM, leds_acesos, erro update next edge.
// Backpressure: none; asserting contaLedsOn and contaLedsOff together freezes everything and sets erro.
// Ports: clock, reset_n (async, active-low), bus (slave side of temporizador_pisca_leds_if).
module temporizador_pisca_leds
    import pisca_pkg::*;
#(
    parameter int T_ON       = T_ON_PADRAO,
    parameter int T_OFF      = T_OFF_PADRAO,
    parameter int N_PISCADAS = N_PISCADAS_PADRAO
) (
    input  logic                            clock,
    input  logic                            reset_n,
    temporizador_pisca_leds_if.slave        bus
);

    localparam int WP = larguraContador(N_PISCADAS);

    estado_t                             estado;
    estado_t                             estadoProx;
    logic                                ledsQ;
    logic                                ledsProx;
    logic                                erroQ;
    logic [WP-1:0]                       cntPisc;
    logic [larguraContador(T_ON)-1:0]    cntOn;
    logic [larguraContador(T_OFF)-1:0]   cntOff;
    logic                                fimOn;
    logic                                fimOff;
    logic                                fimPisc;
    logic                                conflito;
    logic                                contaOn;
    logic                                contaOff;
    logic                                concluiAceso;
    logic                                concluiApagado;
    logic                                unusedContagens;

    // A simultaneous on/off request is ambiguous, so neither counter is allowed to move.
    assign conflito       = bus.contaLedsOn & bus.contaLedsOff;
    assign contaOn        = bus.contaLedsOn & ~conflito;
    assign contaOff       = bus.contaLedsOff & ~conflito;
    assign concluiAceso   = contaOn & fimOn;
    assign concluiApagado = contaOff & fimOff;

    contador_m #(.M(T_ON)) uContadorOn (
        .clock   (clock),
        .reset_n (reset_n),
        .zera    (bus.zeraPisca),
        .conta   (contaOn),
        .Q       (cntOn),
        .fim     (fimOn)
    );

    contador_m #(.M(T_OFF)) uContadorOff (
        .clock   (clock),
        .reset_n (reset_n),
        .zera    (bus.zeraPisca),
        .conta   (contaOff),
        .Q       (cntOff),
        .fim     (fimOff)
    );

    // Only the terminal flags of the phase counters matter at this level.
    assign unusedContagens = ^{cntOn, cntOff};

    // Blink counter: one step per completed on-phase, saturating on the last blink.
    assign fimPisc = (cntPisc == WP'(N_PISCADAS - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cntPisc <= '0;
        end else if (bus.zeraPisca) begin
            cntPisc <= '0;
        end else if (bus.contaPiscadas && concluiAceso && !fimPisc) begin
            cntPisc <= cntPisc + WP'(1);
        end
    end

    // Sticky conflict flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            erroQ <= 1'b0;
        end else if (bus.zeraPisca) begin
            erroQ <= 1'b0;
        end else if (conflito) begin
            erroQ <= 1'b1;
        end
    end

    // FSM state register; leds_acesos is registered alongside so it tracks ACESO exactly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= OCIOSO;
            ledsQ  <= 1'b0;
        end else begin
            estado <= estadoProx;
            ledsQ  <= ledsProx;
        end
    end

    // FSM next state. Enables that do not fit the current state are ignored here even
    // though they still move the counters.
    always_comb begin
        estadoProx = estado;
        if (bus.zeraPisca) begin
            estadoProx = OCIOSO;
        end else if (!conflito) begin
            case (estado)
                OCIOSO:    if (bus.contaLedsOn) estadoProx = ACESO;
                ACESO:     if (concluiAceso)    estadoProx = fimPisc ? CONCLUIDO : APAGADO;
                APAGADO:   if (concluiApagado)  estadoProx = ACESO;
                CONCLUIDO: estadoProx = CONCLUIDO;
                default:   estadoProx = OCIOSO;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        ledsProx = 1'b0;
        if (estadoProx == ACESO) begin
            ledsProx = 1'b1;
        end
    end

    assign bus.fimLedsOn    = fimOn;
    assign bus.fimLedsOff   = fimOff;
    assign bus.fimPiscaLeds = fimPisc;
    assign bus.leds_acesos  = ledsQ;
    assign bus.erro         = erroQ;
    assign bus.db_estado    = estado;

endmodule

// File: tb/tb_temporizador_pisca_leds.sv
module tb_temporizador_pisca_leds;

    localparam int TON  = 4;
    localparam int TOFF = 3;
    localparam int NP   = 3;

    // Phase of the blink sequence as the model sees it; values follow the debug encoding.
    localparam int F_IDLE = 0;
    localparam int F_LIT  = 1;
    localparam int F_DARK = 2;
    localparam int F_DONE = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    int total = 0;
    int bad   = 0;

    // Reference model state: position inside each phase, blinks done, phase, error flag.
    int mOn, mOff, mPisc, mFase;
    bit mErro;

    temporizador_pisca_leds_if ifc ();

    temporizador_pisca_leds #(
        .T_ON       (TON),
        .T_OFF      (TOFF),
        .N_PISCADAS (NP)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifc.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        mOn = 0; mOff = 0; mPisc = 0; mFase = F_IDLE; mErro = 1'b0;
    endtask

    // Expected outputs: {fimLedsOn, fimLedsOff, fimPiscaLeds, leds_acesos, erro, db_estado}
    function automatic logic [6:0] esperado();
        return {mOn == TON - 1, mOff == TOFF - 1, mPisc == NP - 1, mFase == F_LIT, mErro, 2'(mFase)};
    endfunction

    function automatic logic [6:0] observado();
        return {ifc.fimLedsOn, ifc.fimLedsOff, ifc.fimPiscaLeds, ifc.leds_acesos, ifc.erro, ifc.db_estado};
    endfunction

    // Drive one cycle of stimulus, clock it, advance the model, then settle past the edge.
    task automatic ciclo(input bit z, input bit on, input bit off, input bit p);
        bit fimOnAntes;
        bit fimOffAntes;
        ifc.zeraPisca     = z;
        ifc.contaLedsOn   = on;
        ifc.contaLedsOff  = off;
        ifc.contaPiscadas = p;
        @(posedge clock);
        if (z) begin
            model_reset();
        end else if (on && off) begin
            mErro = 1'b1;
        end else begin
            fimOnAntes  = on  && (mOn  == TON - 1);
            fimOffAntes = off && (mOff == TOFF - 1);
            case (mFase)
                F_IDLE: if (on) mFase = F_LIT;
                F_LIT:  if (fimOnAntes) mFase = (mPisc == NP - 1) ? F_DONE : F_DARK;
                F_DARK: if (fimOffAntes) mFase = F_LIT;
                default: ;
            endcase
            if (p && fimOnAntes && mPisc < NP - 1) mPisc++;
            if (on)  mOn  = (mOn + 1) % TON;
            if (off) mOff = (mOff + 1) % TOFF;
        end
        #1;
    endtask

    task automatic test_reset();
        ifc.zeraPisca = 0; ifc.contaLedsOn = 0; ifc.contaLedsOff = 0; ifc.contaPiscadas = 0;
        reset_n = 1'b0;
        model_reset();
        #12;
        total++;
        if (observado() !== 7'b0) begin
            bad++; $display("FAIL reset_state got=%b want=%b", observado(), 7'b0);
        end
        reset_n = 1'b1;
        // Reset in the middle of an on-phase.
        for (int i = 0; i < 2; i++) begin
            ciclo(0, 1, 0, 0);
            total++;
            if (observado() !== esperado()) begin
                bad++; $display("FAIL reset_pre_count got=%b want=%b", observado(), esperado());
            end
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (observado() !== 7'b0) begin
            bad++; $display("FAIL reset_async got=%b want=%b", observado(), 7'b0);
        end
        #3;
        reset_n = 1'b1;
        // Three more steps must land exactly on the terminal count if the counter restarted at 0.
        for (int i = 0; i < 3; i++) ciclo(0, 1, 0, 0);
        total++;
        if (ifc.fimLedsOn !== 1'b1 || observado() !== esperado()) begin
            bad++; $display("FAIL reset_restart got=%b want=%b", observado(), esperado());
        end
        ciclo(1, 0, 0, 0);
    endtask

    task automatic test_single_on_phase();
        ciclo(1, 0, 0, 0);
        for (int i = 1; i <= TON; i++) begin
            ciclo(0, 1, 0, 0);
            total++;
            if (observado() !== esperado()) begin
                bad++; $display("FAIL single_on_model cyc=%0d got=%b want=%b", i, observado(), esperado());
            end
            if (i == TON - 1) begin
                total++;
                if ({ifc.fimLedsOn, ifc.leds_acesos} !== 2'b11) begin
                    bad++; $display("FAIL single_on_fim got=%b want=11", {ifc.fimLedsOn, ifc.leds_acesos});
                end
            end
        end
        total++;
        if ({ifc.fimLedsOn, ifc.leds_acesos, ifc.db_estado} !== 4'b0010) begin
            bad++; $display("FAIL single_on_end got=%b want=0010", {ifc.fimLedsOn, ifc.leds_acesos, ifc.db_estado});
        end
    endtask

    task automatic test_full_sequence();
        ciclo(1, 0, 0, 0);
        for (int ph = 0; ph < 5; ph++) begin
            for (int k = 0; k < ((ph % 2 == 0) ? TON : TOFF); k++) begin
                if (ph == 4 && k == 0) begin
                    total++;
                    if (ifc.fimPiscaLeds !== 1'b1) begin
                        bad++; $display("FAIL full_last_blink got=%b want=1", ifc.fimPiscaLeds);
                    end
                end
                ciclo(0, ph % 2 == 0, ph % 2 == 1, 1);
                total++;
                if (observado() !== esperado()) begin
                    bad++; $display("FAIL full_model ph=%0d k=%0d got=%b want=%b", ph, k, observado(), esperado());
                end
            end
        end
        total++;
        if ({ifc.db_estado, ifc.leds_acesos} !== 3'b110) begin
            bad++; $display("FAIL full_done got=%b want=110", {ifc.db_estado, ifc.leds_acesos});
        end
        // CONCLUIDO holds whatever the enables do.
        ciclo(0, 1, 0, 1);
        total++;
        if (ifc.db_estado !== 2'b11) begin
            bad++; $display("FAIL full_hold got=%b want=11", ifc.db_estado);
        end
    endtask

    task automatic test_conflict();
        ciclo(1, 0, 0, 0);
        ciclo(0, 1, 0, 0);
        ciclo(0, 1, 0, 0);
        ciclo(0, 1, 1, 0);
        total++;
        if ({ifc.erro, ifc.fimLedsOn, ifc.db_estado} !== 4'b1001 || observado() !== esperado()) begin
            bad++; $display("FAIL conflict_set got=%b want=%b", observado(), esperado());
        end
        ciclo(0, 0, 0, 0);
        ciclo(0, 0, 0, 0);
        total++;
        if (ifc.erro !== 1'b1) begin
            bad++; $display("FAIL conflict_sticky got=%b want=1", ifc.erro);
        end
        // One more on-step reaching the terminal count shows the counter stayed at 2.
        ciclo(0, 1, 0, 0);
        total++;
        if ({ifc.fimLedsOn, ifc.db_estado} !== 3'b101) begin
            bad++; $display("FAIL conflict_frozen got=%b want=101", {ifc.fimLedsOn, ifc.db_estado});
        end
        ciclo(1, 0, 0, 0);
        total++;
        if (ifc.erro !== 1'b0) begin
            bad++; $display("FAIL conflict_clear got=%b want=0", ifc.erro);
        end
    endtask

    task automatic test_zera_mid_off();
        ciclo(1, 0, 0, 0);
        for (int i = 0; i < TON; i++) ciclo(0, 1, 0, 1);
        ciclo(0, 0, 1, 1);
        total++;
        if (ifc.db_estado !== 2'b10 || observado() !== esperado()) begin
            bad++; $display("FAIL zera_pre got=%b want=%b", observado(), esperado());
        end
        ciclo(1, 0, 1, 1);
        total++;
        if (observado() !== 7'b0) begin
            bad++; $display("FAIL zera_mid_off got=%b want=%b", observado(), 7'b0);
        end
    endtask

    task automatic test_no_piscadas();
        bit chegou = 1'b0;
        ciclo(1, 0, 0, 0);
        for (int ph = 0; ph < 9; ph++) begin
            for (int k = 0; k < ((ph % 2 == 0) ? TON : TOFF); k++) begin
                ciclo(0, ph % 2 == 0, ph % 2 == 1, 0);
                if (ifc.db_estado === 2'b11 || ifc.fimPiscaLeds === 1'b1) chegou = 1'b1;
                total++;
                if (observado() !== esperado()) begin
                    bad++; $display("FAIL nopisc_model ph=%0d got=%b want=%b", ph, observado(), esperado());
                end
            end
        end
        total++;
        if (chegou !== 1'b0) begin
            bad++; $display("FAIL nopisc_never_done got=%b want=0", chegou);
        end
    endtask

    task automatic test_random();
        int modo;
        bit z, on, off, p;
        ciclo(1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            modo = $urandom_range(0, 9);
            z    = ($urandom_range(0, 31) == 0);
            on   = (modo <= 4) || (modo == 8);
            off  = (modo >= 5 && modo <= 7) || (modo == 8);
            p    = ($urandom_range(0, 3) != 0);
            ciclo(z, on, off, p);
            total++;
            if (observado() !== esperado()) begin
                bad++; $display("FAIL random cyc=%0d got=%b want=%b", i, observado(), esperado());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_on_phase();
        test_full_sequence();
        test_conflict();
        test_zera_mid_off();
        test_no_piscadas();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
